// File: rtl/vga_pkg.sv
//------------------------------------------------------------------------------
// vga_pkg
// 640x480@60 timing defaults, colour constants and shared types.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W    = 10;

  typedef logic [2:0] rgb_t;

  localparam rgb_t BLACK = 3'b000;
  localparam rgb_t BLUE  = 3'b001;
  localparam rgb_t GREEN = 3'b010;
  localparam rgb_t RED   = 3'b100;
  localparam rgb_t WHITE = 3'b111;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } sync_t;

  function automatic logic in_range(logic [CNT_W-1:0] v,
                                    logic [CNT_W-1:0] lo,
                                    logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_if.sv
//------------------------------------------------------------------------------
// vga_if
// Raster coordinates, returned colour and pin-level outputs of the VGA stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface vga_if;
  logic [2:0] color_px;
  logic [9:0] x_px;
  logic [9:0] y_px;
  logic       activevideo;
  logic       line_start;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic       r;
  logic       g;
  logic       b;

  modport master (
    input  color_px,
    output x_px, y_px, activevideo, line_start, frame_start,
    output hsync, vsync, r, g, b
  );

  modport slave (
    output color_px,
    input  x_px, y_px, activevideo, line_start, frame_start,
    input  hsync, vsync, r, g, b
  );
endinterface

`default_nettype wire

// File: rtl/vga_delay.sv
//------------------------------------------------------------------------------
// vga_delay
// WIDTH x DEPTH shift register, asynchronously reset to RST_VAL.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vga_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_timing.sv
//------------------------------------------------------------------------------
// vga_timing
// VGA raster counters, sync generation and pixel output stage. Defining
// VGA_TEST_PATTERN_EN replaces color_px with eight 80-pixel colour bars.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 1
) (
  input  logic  clk,
  input  logic  rst,
  vga_if.master vga
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  generate
    if (H_TOT > 1024 || V_TOT > 1024) begin : g_chk_total
      $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_chk_dly
      $error("vga_timing: PIPE_DLY must be in 1..4");
    end
  endgenerate

  logic             run_q;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             activevideo_q, activevideo_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q         <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      activevideo_q <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      activevideo_q <= activevideo_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // The first edge after reset holds (0,0) so that coordinate is presented
  // as a full clock with frame_start; counting starts on the next edge.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (run_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
    activevideo_d = (h_cnt_d < H_ACT_C) && (v_cnt_d < V_ACT_C);
    line_start_d  = (h_cnt_d == '0);
    frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
  end

  // Raw flags are forced inactive while the held (0,0) clock is shown, so
  // each coordinate enters the delay line exactly once.
  sync_t w_raw;

  always_comb begin
    w_raw.hsync  = (run_q && in_range(h_cnt_q, HS_START, HS_END)) ? HS_POL : ~HS_POL;
    w_raw.vsync  = (run_q && in_range(v_cnt_q, VS_START, VS_END)) ? VS_POL : ~VS_POL;
    w_raw.active = run_q && (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
  end

  sync_t w_dly;
  rgb_t  w_rgb;

`ifdef VGA_TEST_PATTERN_EN
  localparam int                 DLY_W   = 6;
  localparam logic [DLY_W-1:0]   DLY_RST = {~HS_POL, ~VS_POL, 1'b0, BLACK};

  rgb_t             w_bar;
  rgb_t             w_bar_dly;
  logic [DLY_W-1:0] w_dly_q;

  assign w_bar = 3'(h_cnt_q / 10'd80);

  vga_delay #(
    .WIDTH   (DLY_W),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (DLY_RST)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d_i ({w_raw, w_bar}),
    .q_o (w_dly_q)
  );

  assign {w_dly, w_bar_dly} = w_dly_q;
  assign w_rgb = w_dly.active ? w_bar_dly : BLACK;
`else
  localparam int                 DLY_W   = 3;
  localparam logic [DLY_W-1:0]   DLY_RST = {~HS_POL, ~VS_POL, 1'b0};

  logic [DLY_W-1:0] w_dly_q;

  vga_delay #(
    .WIDTH   (DLY_W),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (DLY_RST)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d_i (w_raw),
    .q_o (w_dly_q)
  );

  assign w_dly = w_dly_q;
  // color_px is already PIPE_DLY clocks late, matching the delayed flag.
  assign w_rgb = w_dly.active ? rgb_t'(vga.color_px) : BLACK;
`endif

  assign vga.x_px        = h_cnt_q;
  assign vga.y_px        = v_cnt_q;
  assign vga.activevideo = activevideo_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.hsync       = w_dly.hsync;
  assign vga.vsync       = w_dly.vsync;
  assign vga.r           = w_rgb[2];
  assign vga.g           = w_rgb[1];
  assign vga.b           = w_rgb[0];

endmodule

`default_nettype wire
